// File: rtl/sa_tile_sched_pkg.sv
// sa_tile_sched_pkg: shared defaults, FSM state type and tile-length helper for the tile scheduler
package sa_tile_sched_pkg;
   localparam int N_DEF = 4;
   localparam int SEG_W_DEF = 7;
   localparam int LEN_W_DEF = 8;
   localparam int AW_DEF = 16;
   localparam int CW_DEF = 14;
   localparam int MULT_LAT_DEF = 1;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   // cycles from one tile start to the next: feed L elements, drain the 2N-1 diagonals, multiplier latency
   function automatic int tile_len(input int l, input int n, input int m);
      return l + 2 * n + m;
   endfunction
endpackage

// File: rtl/sa_tile_sched_if.sv
// sa_tile_sched_if: job handshake, RAM access and PE MAC control bundle of the tile scheduler
// master: job issuer (drives start/config, sees status and array controls)
// slave:  scheduler (samples start/config, drives status, RAM strobes and MAC controls)
interface sa_tile_sched_if
   import sa_tile_sched_pkg::*;
#(
   parameter int N = N_DEF,
   parameter int SEG_W = SEG_W_DEF,
   parameter int LEN_W = LEN_W_DEF,
   parameter int AW = AW_DEF,
   parameter int CW = CW_DEF
);
   logic start;
   logic [SEG_W-1:0] a_seg_cnt;
   logic [SEG_W-1:0] w_seg_cnt;
   logic [LEN_W-1:0] seg_length;
   logic acc_into_c;
   logic calc_done;
   logic arr_ctrl_working;
   logic [N-1:0][AW-1:0] ram_a_addr;
   logic [N-1:0] ram_a_rden;
   logic [N-1:0][AW-1:0] ram_w_addr;
   logic [N-1:0] ram_w_rden;
   logic [N-1:0][N-1:0][CW-1:0] ram_c_addr;
   logic [N-1:0][N-1:0] ram_c_wren;
   logic [N-1:0][N-1:0] en_mult_all;
   logic [N-1:0][N-1:0] clr_mult_all;
   logic [N-1:0][N-1:0] en_accum_all;
   logic [N-1:0][N-1:0] clr_accum_all;
   logic [N-1:0][N-1:0] accum_start_all;
   modport master (
      output start, a_seg_cnt, w_seg_cnt, seg_length, acc_into_c,
      input calc_done, arr_ctrl_working, ram_a_addr, ram_a_rden, ram_w_addr, ram_w_rden,
      input ram_c_addr, ram_c_wren, en_mult_all, clr_mult_all, en_accum_all, clr_accum_all, accum_start_all
   );
   modport slave (
      input start, a_seg_cnt, w_seg_cnt, seg_length, acc_into_c,
      output calc_done, arr_ctrl_working, ram_a_addr, ram_a_rden, ram_w_addr, ram_w_rden,
      output ram_c_addr, ram_c_wren, en_mult_all, clr_mult_all, en_accum_all, clr_accum_all, accum_start_all
   );
endinterface

// File: rtl/sa_tile_sched_skew_line.sv
// sa_tile_sched_skew_line: D-deep, 1-bit shift register (D >= 1) with async active-low reset
// Ports: clk, rst_n; din enters the line, dout is din delayed by D cycles (a flop output)
module sa_tile_sched_skew_line #(
   parameter int D = 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic dout
);
   logic [D-1:0] sr_q, sr_d;
   always_comb sr_d = (sr_q << 1) | D'(din);
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sr_q <= '0;
      else sr_q <= sr_d;
   end
   assign dout = sr_q[D-1];
endmodule

// File: rtl/sa_tile_sched.sv
// sa_tile_sched: sequences C = A x W over a_seg_cnt x w_seg_cnt tiles of an NxN systolic array
// Ports: clk; rst_n (async, active-low); bus (slave): start/config in, calc_done/busy out,
//        skewed per-bank A/W reads, per-PE C writes and MAC enables/clears (all registered)
module sa_tile_sched
   import sa_tile_sched_pkg::*;
#(
   parameter int N = N_DEF,
   parameter int SEG_W = SEG_W_DEF,
   parameter int LEN_W = LEN_W_DEF,
   parameter int AW = AW_DEF,
   parameter int CW = CW_DEF,
   parameter int MULT_LAT = MULT_LAT_DEF
) (
   input logic clk,
   input logic rst_n,
   sa_tile_sched_if.slave bus
);
   localparam int CNT_W = LEN_W + $clog2(2 * N + MULT_LAT + 1) + 1;
   localparam logic [CNT_W-1:0] ML = CNT_W'(MULT_LAT);
   state_t state_q, state_d;
   logic [CNT_W-1:0] c_q, c_d;
   logic [SEG_W-1:0] ta_q, ta_d, tw_q, tw_d, aseg_q, aseg_d, wseg_q, wseg_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic acc_q, acc_d;
   logic [AW-1:0] base_a_q, base_a_d, base_w_q, base_w_d;
   logic [CW-1:0] cadr_q, cadr_d;
   logic [N-1:0] rd_q, rd_d;
   logic [N-1:0][AW-1:0] aa_q, aa_d, wa_q, wa_d;
   logic clr_q, clr_d, done_q, done_d, busy_q, busy_d, run_d, tile_end;
   // tile-level pulse trains as seen by diagonal 0: {wren, accum_start, en_accum, en_mult}
   logic [3:0] src_d;
   logic [2*N-2:0][3:0] diag;
   assign tile_end = c_q == CNT_W'(tile_len(int'(len_q), N, MULT_LAT) - 1);
   always_comb begin
      state_d = state_q;
      c_d = c_q + 1'b1;
      ta_d = ta_q;
      tw_d = tw_q;
      aseg_d = aseg_q;
      wseg_d = wseg_q;
      len_d = len_q;
      acc_d = acc_q;
      base_a_d = base_a_q;
      base_w_d = base_w_q;
      cadr_d = cadr_q;
      if (state_q == IDLE) begin
         c_d = '0;
         ta_d = '0;
         tw_d = '0;
         base_a_d = '0;
         base_w_d = '0;
         cadr_d = '0;
         if (bus.start) begin
            aseg_d = bus.a_seg_cnt;
            wseg_d = bus.w_seg_cnt;
            len_d = bus.seg_length;
            acc_d = bus.acc_into_c;
            state_d = (bus.a_seg_cnt == '0 || bus.w_seg_cnt == '0 || bus.seg_length == '0) ? DONE : RUN;
         end
      end else if (state_q == DONE) begin
         state_d = IDLE;
         c_d = '0;
         cadr_d = '0;
      end else if (tile_end) begin
         // segment bases advance by L per tile as running sums
         c_d = '0;
         cadr_d = cadr_q + 1'b1;
         tw_d = tw_q + 1'b1;
         base_w_d = base_w_q + AW'(len_q);
         if (tw_q == wseg_q - 1'b1) begin
            tw_d = '0;
            base_w_d = '0;
            ta_d = ta_q + 1'b1;
            base_a_d = base_a_q + AW'(len_q);
            if (ta_q == aseg_q - 1'b1) state_d = DONE;
         end
      end
   end
   // outputs are computed from next-cycle state so the registered copies line up with c
   always_comb begin
      run_d = state_d == RUN;
      rd_d = '0;
      aa_d = '0;
      wa_d = '0;
      for (int i = 0; i < N; i++) begin
         if (run_d && c_d >= CNT_W'(i) && c_d - CNT_W'(i) < CNT_W'(len_d)) begin
            rd_d[i] = 1'b1;
            aa_d[i] = base_a_d + AW'(c_d - CNT_W'(i));
            wa_d[i] = base_w_d + AW'(c_d - CNT_W'(i));
         end
      end
      src_d[0] = run_d && c_d >= CNT_W'(1) && c_d <= CNT_W'(len_d);
      src_d[1] = run_d && c_d > ML && c_d <= CNT_W'(len_d) + ML;
      src_d[2] = run_d && c_d == ML + 1'b1;
      src_d[3] = run_d && c_d == CNT_W'(len_d) + ML + 1'b1;
      clr_d = run_d && c_d == '0 && (!acc_d || (ta_d == '0 && tw_d == '0));
      done_d = state_d == DONE;
      busy_d = state_d != IDLE;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         c_q <= '0;
         ta_q <= '0;
         tw_q <= '0;
         aseg_q <= '0;
         wseg_q <= '0;
         len_q <= '0;
         acc_q <= 1'b0;
         base_a_q <= '0;
         base_w_q <= '0;
         cadr_q <= '0;
         rd_q <= '0;
         aa_q <= '0;
         wa_q <= '0;
         clr_q <= 1'b0;
         done_q <= 1'b0;
         busy_q <= 1'b0;
      end else begin
         state_q <= state_d;
         c_q <= c_d;
         ta_q <= ta_d;
         tw_q <= tw_d;
         aseg_q <= aseg_d;
         wseg_q <= wseg_d;
         len_q <= len_d;
         acc_q <= acc_d;
         base_a_q <= base_a_d;
         base_w_q <= base_w_d;
         cadr_q <= cadr_d;
         rd_q <= rd_d;
         aa_q <= aa_d;
         wa_q <= wa_d;
         clr_q <= clr_d;
         done_q <= done_d;
         busy_q <= busy_d;
      end
   end
   // diagonal d = i+j sees each train d cycles later; the extra stage is the output register
   for (genvar d = 0; d < 2 * N - 1; d++) begin : g_diag
      for (genvar s = 0; s < 4; s++) begin : g_sig
         sa_tile_sched_skew_line #(.D(d + 1)) u_line (
            .clk(clk), .rst_n(rst_n), .din(src_d[s]), .dout(diag[d][s])
         );
      end
   end
   for (genvar i = 0; i < N; i++) begin : g_row
      for (genvar j = 0; j < N; j++) begin : g_col
         assign bus.en_mult_all[i][j] = diag[i+j][0];
         assign bus.en_accum_all[i][j] = diag[i+j][1];
         assign bus.accum_start_all[i][j] = diag[i+j][2];
         assign bus.ram_c_wren[i][j] = diag[i+j][3];
         assign bus.clr_mult_all[i][j] = clr_q;
         assign bus.clr_accum_all[i][j] = clr_q;
         assign bus.ram_c_addr[i][j] = cadr_q;
      end
   end
   assign bus.ram_a_rden = rd_q;
   assign bus.ram_w_rden = rd_q;
   assign bus.ram_a_addr = aa_q;
   assign bus.ram_w_addr = wa_q;
   assign bus.calc_done = done_q;
   assign bus.arr_ctrl_working = busy_q;
endmodule

// File: tb/tb_sa_tile_sched.sv
// tb_sa_tile_sched: scoreboard bench comparing every output of sa_tile_sched cycle by cycle
module tb_sa_tile_sched;
   localparam int N = 4;
   localparam int SEG_W = 7;
   localparam int LEN_W = 8;
   localparam int AW = 16;
   localparam int CW = 14;
   localparam int M = 1;
   typedef struct packed {
      logic [N-1:0] ar, wr;
      logic [N-1:0][AW-1:0] aa, wa;
      logic [N-1:0][N-1:0] em, ea, ast, wren, clr;
      logic done, busy, chk_ca;
      logic [CW-1:0] ca;
   } exp_t;
   logic clk = 1'b0;
   logic rst_n = 1'b1;
   int n_tests = 0;
   int n_fail = 0;
   exp_t sb[$];
   always #5 clk = ~clk;
   sa_tile_sched_if #(.N(N), .SEG_W(SEG_W), .LEN_W(LEN_W), .AW(AW), .CW(CW)) bus ();
   sa_tile_sched #(.N(N), .SEG_W(SEG_W), .LEN_W(LEN_W), .AW(AW), .CW(CW), .MULT_LAT(M)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus)
   );
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
      end
   endtask
   // expected outputs for cycle n of a job, straight from the tile/diagonal formulas
   function automatic exp_t model(input int n, input int a, input int w, input int l, input bit acc);
      exp_t e = '0;
      int t = l + 2 * N + M;
      int last = a * w * t;
      if (a == 0 || w == 0 || l == 0) begin
         e.done = n == 0;
         e.busy = n == 0;
         return e;
      end
      e.busy = n <= last;
      e.done = n == last;
      if (n < last) begin
         int tile = n / t;
         int c = n % t;
         int ta = tile / w;
         int tw = tile % w;
         e.chk_ca = 1'b1;
         e.ca = CW'(ta * w + tw);
         e.clr = {(N * N){c == 0 && (!acc || tile == 0)}};
         for (int i = 0; i < N; i++) begin
            if (c - i >= 0 && c - i < l) begin
               e.ar[i] = 1'b1;
               e.wr[i] = 1'b1;
               e.aa[i] = AW'(ta * l + c - i);
               e.wa[i] = AW'(tw * l + c - i);
            end
            for (int j = 0; j < N; j++) begin
               e.em[i][j] = c >= i + j + 1 && c <= i + j + l;
               e.ea[i][j] = c >= i + j + 1 + M && c <= i + j + l + M;
               e.ast[i][j] = c == i + j + 1 + M;
               e.wren[i][j] = c == i + j + l + M + 1;
            end
         end
      end
      return e;
   endfunction
   always @(negedge clk) begin : mon
      exp_t e;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         check("a_rden", 64'(bus.ram_a_rden), 64'(e.ar));
         check("w_rden", 64'(bus.ram_w_rden), 64'(e.wr));
         check("a_addr", 64'(bus.ram_a_addr), 64'(e.aa));
         check("w_addr", 64'(bus.ram_w_addr), 64'(e.wa));
         check("en_mult", 64'(bus.en_mult_all), 64'(e.em));
         check("en_accum", 64'(bus.en_accum_all), 64'(e.ea));
         check("accum_start", 64'(bus.accum_start_all), 64'(e.ast));
         check("c_wren", 64'(bus.ram_c_wren), 64'(e.wren));
         check("clr_mult", 64'(bus.clr_mult_all), 64'(e.clr));
         check("clr_accum", 64'(bus.clr_accum_all), 64'(e.clr));
         check("calc_done", 64'(bus.calc_done), 64'(e.done));
         check("working", 64'(bus.arr_ctrl_working), 64'(e.busy));
         if (e.chk_ca)
            for (int i = 0; i < N; i++)
               for (int j = 0; j < N; j++)
                  check("c_addr", 64'(bus.ram_c_addr[i][j]), 64'(e.ca));
      end
   end
   task automatic do_reset();
      exp_t z = '0;
      z.chk_ca = 1'b1;
      rst_n = 1'b0;
      sb.delete();
      repeat (3) sb.push_back(z);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
   endtask
   task automatic run_job(input int a, input int w, input int l, input bit acc,
                          input int restart_at = -1, input int rst_at = -1);
      int last = (a == 0 || w == 0 || l == 0) ? 0 : a * w * (l + 2 * N + M);
      int t = 0;
      @(negedge clk);
      bus.a_seg_cnt = SEG_W'(a);
      bus.w_seg_cnt = SEG_W'(w);
      bus.seg_length = LEN_W'(l);
      bus.acc_into_c = acc;
      bus.start = 1'b1;
      @(posedge clk);
      #1 bus.start = 1'b0;
      for (int n = 0; n <= last + 2; n++) sb.push_back(model(n, a, w, l, acc));
      if (restart_at >= 0) begin
         repeat (restart_at) @(posedge clk);
         #1;
         bus.a_seg_cnt = 1;
         bus.w_seg_cnt = 1;
         bus.seg_length = 2;
         bus.acc_into_c = ~acc;
         bus.start = 1'b1;
         @(posedge clk);
         #1 bus.start = 1'b0;
      end
      if (rst_at >= 0) begin
         repeat (rst_at) @(posedge clk);
         #1 do_reset();
      end
      while (sb.size() > 0 && t < 5000) begin
         @(posedge clk);
         t++;
      end
      check("drain", 64'(sb.size()), 64'(0));
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish in time");
      $fatal(1, "watchdog expired");
   end
   initial begin
      bus.start = 1'b0;
      bus.a_seg_cnt = '0;
      bus.w_seg_cnt = '0;
      bus.seg_length = '0;
      bus.acc_into_c = 1'b0;
      #1 do_reset();
      run_job(1, 1, 3, 1'b0);
      run_job(2, 3, 5, 1'b0);
      run_job(2, 2, 0, 1'b0);
      run_job(0, 3, 4, 1'b1);
      run_job(2, 3, 5, 1'b0, 4, -1);
      run_job(2, 3, 5, 1'b0, -1, 7);
      run_job(2, 3, 5, 1'b0);
      run_job(2, 2, 4, 1'b1);
      run_job(1, 2, 1, 1'b1);
      run_job(3, 1, 7, 1'b0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
